sfp_decoder: RTL and testbench
==============================

// Module: sfp_decoder
// PURPOSE
//  RX-side frame decoder; sits between GT receiver (32-bit, 4-lane charisk) and the video sink.
//  Strips idle/comma fill, recovers VS pulse and payload frames delimited by K-word pairs
//  (VS1/VS2, START1/START2, END1/END2), counts payload words, flags protocol errors, tracks link.
// PARAMETERS
//  VS_POSE_DATA1  32'h55a101bc  VS marker word 1 (charisk 4'b0001)
//  VS_POSE_DATA2  32'h55a102bc  VS marker word 2
//  DATA_START1    32'h55a105bc  SOF marker word 1
//  DATA_START2    32'h55a106bc  SOF marker word 2
//  DATA_END1      32'h55a107bc  EOF marker word 1
//  DATA_END2      32'h55a108bc  EOF marker word 2
//  UNUSE_DATA     32'h55a109bc  periodic comma/keepalive K-word
//  LINK_TIMEOUT   4096          rx_clk cycles without any valid K-word before link_ok drops
// PORTS
//  rx_clk          in   1   GT RX user clock
//  rx_rst_n        in   1   async active-low reset
//  gt_rxdata       in   32  received word
//  gt_rxcharisk    in   4   per-byte K flags
//  vs_out          out  1   1-cycle pulse on completed VS1/VS2 pair
//  sof_out         out  1   1-cycle pulse on completed START1/START2 pair
//  data_valid_out  out  1   payload qualifier
//  data_out        out  32  payload word
//  eof_out         out  1   1-cycle pulse on completed END1/END2 pair
//  frame_words     out  16  payload words of last good frame; valid with eof_out, held till next sof_out
//  frame_err       out  1   1-cycle pulse on aborted/malformed frame
//  link_ok         out  1   link status
//  stat_frames/stat_errs/stat_vs  out 16 each  statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, data_out 32'h0.
//  Stage 1 registers gt_rxdata/gt_rxcharisk; FSM acts on stage 1; outputs registered: latency 2 cycles.
//  K-word = charisk 4'b0001 and data equal to a parameter; charisk 4'b0001 other value = unknown K;
//  charisk not in {0000,0001} = bad K (misaligned).
//  FSM: IDLE, VS1, SOF1, DATA, EOF1.
//   IDLE: VS1 word->VS1; START1->SOF1; all else (fill 32'ha151a252, UNUSE_DATA, data) ignored.
//   VS1:  VS2->vs_out, IDLE; else IDLE (no pulse, no error).
//   SOF1: START2->sof_out, word count=0, DATA; else IDLE.
//   DATA: charisk 0000 -> data_valid_out, count+1 (saturate 16'hFFFF);
//         END1->EOF1; VS1 or START1 -> frame_err, go VS1/SOF1 (abort, marker honoured);
//         any other K or bad K -> frame_err, IDLE.
//   EOF1: END2->eof_out, frame_words=count, IDLE; else frame_err, IDLE.
//  Zero-length frame (START2 then END1/END2) legal: eof_out with frame_words=0.
//  link_ok: set on any valid K-word; cleared on bad K or LINK_TIMEOUT cycles without K-word;
//  timeout counter cleared on each K-word. link_ok does not gate the FSM.
//  Async reset mid-frame: everything returns to reset values; no eof/err emitted.
// CONFIGURATION
//  SFP_DEC_STAT_EN defined: stat_frames (eof_out), stat_errs (frame_err), stat_vs (vs_out) are
//   16-bit saturating counters, reset 0.
//  Not defined: stat_* tied to 16'h0, counter logic absent; all other behaviour identical.
// STRUCTURE
//  sfp_pkg: K-word default constants, fill word 32'ha151a252, FSM state enum, charisk codes.
//  Sub-module sfp_link_monitor: link_ok + timeout counter (inputs: k_valid, k_bad).
// TESTING
//  Idle fill + UNUSE_DATA every 256 cycles -> no outputs pulse, link_ok=1 after first comma.
//  VS1,VS2 -> vs_out one pulse 2 cycles after VS2 word; VS1,fill -> no pulse, no error.
//  START1,START2, 500 words 0..499, END1,END2 -> 500 data_valid_out in order, eof_out, frame_words=500.
//  START pair, 10 words, VS1,VS2 -> frame_err pulse at VS1, then vs_out; no eof_out, frame_words unchanged.
//  Charisk 4'b0010 in DATA -> frame_err, link_ok=0, IDLE; next START pair decodes normally.
//  No K-word for 4096 cycles -> link_ok=0; with SFP_DEC_STAT_EN stat counters match event counts.

Source files
------------

// File: rtl/sfp_pkg.sv
// sfp_pkg: shared constants and types for the SFP RX frame decoder.
// Holds the default K-word marker values, the idle fill word, charisk codes,
// the decoder FSM state enum, the decoded-word classification and a saturating
// increment helper.
package sfp_pkg;

  localparam logic [31:0] VS_POSE_DATA1_DEF = 32'h55a101bc;
  localparam logic [31:0] VS_POSE_DATA2_DEF = 32'h55a102bc;
  localparam logic [31:0] DATA_START1_DEF   = 32'h55a105bc;
  localparam logic [31:0] DATA_START2_DEF   = 32'h55a106bc;
  localparam logic [31:0] DATA_END1_DEF     = 32'h55a107bc;
  localparam logic [31:0] DATA_END2_DEF     = 32'h55a108bc;
  localparam logic [31:0] UNUSE_DATA_DEF    = 32'h55a109bc;
  localparam logic [31:0] FILL_WORD         = 32'ha151a252;
  localparam int          LINK_TIMEOUT_DEF  = 4096;

  // Per-byte K flags: plain data, and a K character in the low byte only.
  localparam logic [3:0]  CHARISK_DATA = 4'b0000;
  localparam logic [3:0]  CHARISK_K    = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS1,
    ST_SOF1,
    ST_DATA,
    ST_EOF1
  } state_e;

  // Classification of one received word after the input register.
  typedef enum logic [3:0] {
    KW_DATA,
    KW_VS1,
    KW_VS2,
    KW_START1,
    KW_START2,
    KW_END1,
    KW_END2,
    KW_UNUSE,
    KW_UNKNOWN,
    KW_BAD
  } kword_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sfp_link_monitor.sv
// sfp_link_monitor: link status tracker for the SFP RX decoder.
// link_ok rises on any recognised K-word, falls on a misaligned charisk or
// after TIMEOUT consecutive cycles without a recognised K-word.
module sfp_link_monitor #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic k_valid_i,
  input  logic k_bad_i,
  output logic link_ok_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          link_q;

  // Idle counter saturates at LIM; link drops once LIM cycles have elapsed with no K-word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      link_q <= 1'b0;
    end else if (k_valid_i) begin
      cnt_q  <= '0;
      link_q <= 1'b1;
    end else begin
      if (cnt_q != LIM) cnt_q <= cnt_q + 1'b1;
      if (k_bad_i || (cnt_q == LIM)) link_q <= 1'b0;
    end
  end

  assign link_ok_o = link_q;

endmodule

// File: rtl/sfp_decoder.sv
// sfp_decoder: RX-side frame decoder between the GT receiver and the video sink.
// Strips fill, recovers VS pulses and START/END delimited payload frames,
// counts payload words, flags malformed frames and tracks link status.
// Latency: input register + registered FSM outputs = 2 cycles.
// Optional build macro SFP_DEC_STAT_EN enables the 16-bit saturating
// statistics counters; without it the stat_* outputs are tied to zero.
module sfp_decoder
  import sfp_pkg::*;
#(
  parameter logic [31:0] VS_POSE_DATA1 = VS_POSE_DATA1_DEF,
  parameter logic [31:0] VS_POSE_DATA2 = VS_POSE_DATA2_DEF,
  parameter logic [31:0] DATA_START1   = DATA_START1_DEF,
  parameter logic [31:0] DATA_START2   = DATA_START2_DEF,
  parameter logic [31:0] DATA_END1     = DATA_END1_DEF,
  parameter logic [31:0] DATA_END2     = DATA_END2_DEF,
  parameter logic [31:0] UNUSE_DATA    = UNUSE_DATA_DEF,
  parameter int          LINK_TIMEOUT  = LINK_TIMEOUT_DEF
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic [31:0] gt_rxdata,
  input  logic [3:0]  gt_rxcharisk,
  output logic        vs_out,
  output logic        sof_out,
  output logic        data_valid_out,
  output logic [31:0] data_out,
  output logic        eof_out,
  output logic [15:0] frame_words,
  output logic        frame_err,
  output logic        link_ok,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errs,
  output logic [15:0] stat_vs
);

  logic [31:0] rxdata_q;
  logic [3:0]  rxk_q;
  kword_e      kw;
  logic        k_valid;
  logic        k_bad;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] frame_words_q;
  logic [31:0] data_q;
  logic        dv_q;
  logic        vs_q;
  logic        sof_q;
  logic        eof_q;
  logic        err_q;

  // Stage 1: register the raw GT word and its K flags.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rxdata_q <= 32'h0;
      rxk_q    <= 4'h0;
    end else begin
      rxdata_q <= gt_rxdata;
      rxk_q    <= gt_rxcharisk;
    end
  end

  // Classify the stage-1 word as data, a known marker, an unknown K or misaligned K.
  always_comb begin
    kw = KW_BAD;
    if (rxk_q == CHARISK_DATA) begin
      kw = KW_DATA;
    end else if (rxk_q == CHARISK_K) begin
      if      (rxdata_q == VS_POSE_DATA1) kw = KW_VS1;
      else if (rxdata_q == VS_POSE_DATA2) kw = KW_VS2;
      else if (rxdata_q == DATA_START1)   kw = KW_START1;
      else if (rxdata_q == DATA_START2)   kw = KW_START2;
      else if (rxdata_q == DATA_END1)     kw = KW_END1;
      else if (rxdata_q == DATA_END2)     kw = KW_END2;
      else if (rxdata_q == UNUSE_DATA)    kw = KW_UNUSE;
      else                                kw = KW_UNKNOWN;
    end
  end

  assign k_valid = (kw != KW_DATA) && (kw != KW_UNKNOWN) && (kw != KW_BAD);
  assign k_bad   = (kw == KW_BAD);

  // Stage 2: frame FSM with registered pulses, payload and word count.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= 16'h0;
      frame_words_q <= 16'h0;
      data_q        <= 32'h0;
      dv_q          <= 1'b0;
      vs_q          <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      vs_q  <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (kw == KW_VS1)         state_q <= ST_VS1;
          else if (kw == KW_START1) state_q <= ST_SOF1;
        end
        ST_VS1: begin
          if (kw == KW_VS2) vs_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_SOF1: begin
          if (kw == KW_START2) begin
            sof_q   <= 1'b1;
            count_q <= 16'h0;
            state_q <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          case (kw)
            KW_DATA: begin
              dv_q    <= 1'b1;
              data_q  <= rxdata_q;
              count_q <= sat_inc16(count_q);
            end
            KW_END1:   state_q <= ST_EOF1;
            // A new marker aborts the frame but is still honoured.
            KW_VS1: begin
              err_q   <= 1'b1;
              state_q <= ST_VS1;
            end
            KW_START1: begin
              err_q   <= 1'b1;
              state_q <= ST_SOF1;
            end
            default: begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          endcase
        end
        ST_EOF1: begin
          if (kw == KW_END2) begin
            eof_q         <= 1'b1;
            frame_words_q <= count_q;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sfp_link_monitor #(
    .TIMEOUT (LINK_TIMEOUT)
  ) u_link_monitor (
    .clk_i     (rx_clk),
    .rst_ni    (rx_rst_n),
    .k_valid_i (k_valid),
    .k_bad_i   (k_bad),
    .link_ok_o (link_ok)
  );

  assign vs_out         = vs_q;
  assign sof_out        = sof_q;
  assign data_valid_out = dv_q;
  assign data_out       = data_q;
  assign eof_out        = eof_q;
  assign frame_words    = frame_words_q;
  assign frame_err      = err_q;

`ifdef SFP_DEC_STAT_EN
  logic [15:0] stat_frames_q;
  logic [15:0] stat_errs_q;
  logic [15:0] stat_vs_q;

  // Event counters follow the registered pulses, saturating at 16'hFFFF.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      stat_frames_q <= 16'h0;
      stat_errs_q   <= 16'h0;
      stat_vs_q     <= 16'h0;
    end else begin
      if (eof_q) stat_frames_q <= sat_inc16(stat_frames_q);
      if (err_q) stat_errs_q   <= sat_inc16(stat_errs_q);
      if (vs_q)  stat_vs_q     <= sat_inc16(stat_vs_q);
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errs   = stat_errs_q;
  assign stat_vs     = stat_vs_q;
`else
  assign stat_frames = 16'h0;
  assign stat_errs   = 16'h0;
  assign stat_vs     = 16'h0;
`endif

endmodule

// File: tb/tb_sfp_decoder.sv
// tb_sfp_decoder: scoreboard bench for sfp_decoder.
// Each driven word that should produce an output pushes an expected token
// (kind, value, output cycle); a negedge monitor pops and compares on every pulse.
module tb_sfp_decoder;

  localparam logic [31:0] W_VS1   = 32'h55a101bc;
  localparam logic [31:0] W_VS2   = 32'h55a102bc;
  localparam logic [31:0] W_ST1   = 32'h55a105bc;
  localparam logic [31:0] W_ST2   = 32'h55a106bc;
  localparam logic [31:0] W_END1  = 32'h55a107bc;
  localparam logic [31:0] W_END2  = 32'h55a108bc;
  localparam logic [31:0] W_UNUSE = 32'h55a109bc;
  localparam logic [31:0] W_FILL  = 32'ha151a252;
  localparam logic [3:0]  KD = 4'b0000;
  localparam logic [3:0]  KK = 4'b0001;

  localparam int T_VS = 1, T_SOF = 2, T_DATA = 3, T_EOF = 4, T_ERR = 5;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic [31:0] gt_rxdata = 32'ha151a252;
  logic [3:0]  gt_rxcharisk = 4'b0000;
  logic        vs_out, sof_out, data_valid_out, eof_out, frame_err, link_ok;
  logic [31:0] data_out;
  logic [15:0] frame_words, stat_frames, stat_errs, stat_vs;

  sfp_decoder dut (
    .rx_clk         (rx_clk),
    .rx_rst_n       (rx_rst_n),
    .gt_rxdata      (gt_rxdata),
    .gt_rxcharisk   (gt_rxcharisk),
    .vs_out         (vs_out),
    .sof_out        (sof_out),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .eof_out        (eof_out),
    .frame_words    (frame_words),
    .frame_err      (frame_err),
    .link_ok        (link_ok),
    .stat_frames    (stat_frames),
    .stat_errs      (stat_errs),
    .stat_vs        (stat_vs)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } tok_t;

  tok_t q[$];
  int errors = 0;
  int checks = 0;
  int drv_cyc = 0;
  int n_eof = 0, n_err = 0, n_vs = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k);
    @(posedge rx_clk);
    #1;
    gt_rxdata    = d;
    gt_rxcharisk = k;
    drv_cyc      = cyc;
  endtask

  task automatic expect_tok(input int kind, input logic [31:0] val);
    tok_t t;
    t.kind = kind;
    t.val  = val;
    t.cyc  = drv_cyc + 2;
    q.push_back(t);
    if (kind == T_EOF) n_eof++;
    if (kind == T_ERR) n_err++;
    if (kind == T_VS)  n_vs++;
  endtask

  task automatic match(input int kind, input logic [31:0] val);
    tok_t t;
    check_eq("pulse_expected", 64'(q.size() > 0), 64'd1);
    if (q.size() > 0) begin
      t = q.pop_front();
      check_eq("pulse_kind", 64'(kind), 64'(t.kind));
      check_eq("pulse_cycle", 64'(cyc), 64'(t.cyc));
      if (kind == T_DATA || kind == T_EOF) check_eq("pulse_value", 64'(val), 64'(t.val));
    end
  endtask

  // Output monitor: every pulse must match the oldest expected token.
  always @(negedge rx_clk) begin
    if (rx_rst_n) begin
      if (vs_out)         match(T_VS, 32'h0);
      if (sof_out)        match(T_SOF, 32'h0);
      if (data_valid_out) match(T_DATA, data_out);
      if (eof_out)        match(T_EOF, {16'h0, frame_words});
      if (frame_err)      match(T_ERR, 32'h0);
    end
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(W_FILL, KD);
  endtask

  task automatic start_pair();
    drive(W_ST1, KK);
    drive(W_ST2, KK);
    expect_tok(T_SOF, 32'h0);
  endtask

  task automatic payload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      drive(base + 32'(i), KD);
      expect_tok(T_DATA, base + 32'(i));
    end
  endtask

  task automatic end_pair(input int words);
    drive(W_END1, KK);
    drive(W_END2, KK);
    expect_tok(T_EOF, 32'(words));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge rx_clk);
    #1;
    check_eq("rst_pulses", {58'h0, vs_out, sof_out, data_valid_out, eof_out, frame_err, link_ok}, 64'h0);
    check_eq("rst_data_out", 64'(data_out), 64'h0);
    check_eq("rst_frame_words", 64'(frame_words), 64'h0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;

    // Idle fill with periodic comma: nothing pulses, link comes up
    for (int i = 0; i < 600; i++) begin
      if (i % 256 == 0) drive(W_UNUSE, KK);
      else              drive(W_FILL, KD);
    end
    check_eq("idle_link_ok", 64'(link_ok), 64'd1);

    // VS pair pulses once; VS1 followed by fill is silently dropped
    drive(W_VS1, KK);
    drive(W_VS2, KK);
    expect_tok(T_VS, 32'h0);
    fill(4);
    drive(W_VS1, KK);
    fill(4);

    // 500-word frame
    start_pair();
    payload(500, 32'h0);
    end_pair(500);
    fill(4);
    check_eq("frame_words_500", 64'(frame_words), 64'd500);

    // Abort by VS marker: error at VS1, then VS honoured, word count held
    start_pair();
    payload(10, 32'h1000);
    drive(W_VS1, KK);
    expect_tok(T_ERR, 32'h0);
    drive(W_VS2, KK);
    expect_tok(T_VS, 32'h0);
    fill(4);
    check_eq("abort_frame_words", 64'(frame_words), 64'd500);

    // Misaligned charisk inside a frame drops link and aborts
    start_pair();
    payload(3, 32'h2000);
    drive(32'h12345678, 4'b0010);
    expect_tok(T_ERR, 32'h0);
    fill(4);
    check_eq("badk_link_ok", 64'(link_ok), 64'd0);
    start_pair();
    payload(5, 32'h3000);
    end_pair(5);
    fill(4);
    check_eq("recover_link_ok", 64'(link_ok), 64'd1);
    check_eq("recover_frame_words", 64'(frame_words), 64'd5);

    // Unknown K inside a frame aborts to IDLE; link unaffected
    start_pair();
    payload(2, 32'h4000);
    drive(32'h55a1ffbc, KK);
    expect_tok(T_ERR, 32'h0);
    fill(4);
    check_eq("unknownk_link_ok", 64'(link_ok), 64'd1);

    // Asynchronous reset mid-frame
    start_pair();
    payload(3, 32'h5000);
    repeat (3) @(negedge rx_clk);
    #2;
    rx_rst_n = 1'b0;
    #1;
    check_eq("midrst_pulses", {58'h0, vs_out, sof_out, data_valid_out, eof_out, frame_err, link_ok}, 64'h0);
    check_eq("midrst_frame_words", 64'(frame_words), 64'h0);
    check_eq("midrst_data_out", 64'(data_out), 64'h0);
    check_eq("midrst_queue_drained", 64'(q.size()), 64'd0);
    gt_rxdata    = W_FILL;
    gt_rxcharisk = KD;
    n_eof = 0;
    n_err = 0;
    n_vs  = 0;
    repeat (2) @(negedge rx_clk);
    rx_rst_n = 1'b1;
    fill(4);

    // Zero-length frame
    start_pair();
    end_pair(0);
    fill(4);
    check_eq("zero_frame_words", 64'(frame_words), 64'd0);

    // Link timeout after 4096 cycles without a K-word
    drive(W_UNUSE, KK);
    fill(4090);
    check_eq("timeout_before", 64'(link_ok), 64'd1);
    fill(10);
    check_eq("timeout_after", 64'(link_ok), 64'd0);

    fill(6);
    check_eq("queue_empty", 64'(q.size()), 64'd0);
`ifdef SFP_DEC_STAT_EN
    check_eq("stat_frames", 64'(stat_frames), 64'(n_eof));
    check_eq("stat_errs", 64'(stat_errs), 64'(n_err));
    check_eq("stat_vs", 64'(stat_vs), 64'(n_vs));
`else
    check_eq("stat_tied_zero", {16'h0, stat_frames, stat_errs, stat_vs}, 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound in case the stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
